pixel_streamer: RTL and testbench
=================================

// Module: pixel_streamer
// PURPOSE
//  Frame source that feeds the 3x3 window line buffer. It reads a raster-order 8-bit
//  greyscale image from a 1-cycle-latency frame memory and drives pixel_out/shift_en
//  into the line buffer, honouring downstream backpressure.
//  It also tracks how far the line buffer has filled and flags the cycles on which the
//  buffer's 3x3 window is complete and interior, giving the window's centre coordinates.
//  Sits between frame memory and the line buffer / Sobel datapath.
// PARAMETERS
//  IMG_WIDTH   540                            pixels per row (>=3)
//  IMG_HEIGHT  540                            rows per frame (>=3)
//  ADDR_WIDTH  $clog2(IMG_WIDTH*IMG_HEIGHT)   frame memory address width
// PORTS
//  clock         in   1           rising-edge clock
//  reset_n       in   1           asynchronous, active-low reset
//  start         in   1           1-cycle pulse: begin streaming one frame
//  busy          out  1           frame in progress (start..done inclusive)
//  done          out  1           1-cycle pulse after the last pixel is shifted out
//  frame_clear   out  1           1-cycle pulse on accepted start; downstream zeroes its buffer
//  mem_rd_en     out  1           read strobe to frame memory
//  mem_addr      out  ADDR_WIDTH  read address (row*IMG_WIDTH + col)
//  mem_rd_data   in   8           read data, valid exactly 1 cycle after mem_rd_en
//  out_ready     in   1           downstream can accept a pixel this cycle
//  shift_en      out  1           pixel_out is transferred this cycle
//  pixel_out     out  8           pixel to line buffer
//  window_valid  out  1           line-buffer window is a full interior 3x3 (cycle after shift)
//  center_row    out  $clog2(IMG_HEIGHT)  row of window centre (valid with window_valid)
//  center_col    out  $clog2(IMG_WIDTH)   col of window centre (valid with window_valid)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, counters 0. Async assert, sync-style deassert use.
//  FSM:
//   - IDLE->RUN on start (frame_clear=1 same cycle, rd_addr=0, shift_cnt=0).
//   - RUN->FLUSH when read W*H-1 issued.
//   - FLUSH->DONE when FIFO empty and no read in flight.
//   - DONE->IDLE after 1 cycle (done=1 in DONE). start ignored outside IDLE.
//  Reads:
//   - 2-entry FIFO buffers return data.
//   - mem_rd_en=1 in RUN iff (fifo_count + inflight - pop) < 2; mem_addr increments per read.
//   - Read returns write the FIFO unconditionally; FIFO never overflows by construction.
//  Output:
//   - shift_en = fifo_not_empty & out_ready (combinational on out_ready); pixel_out = FIFO head.
//   - pop on shift_en. Simultaneous push+pop keeps count.
//   - out_ready held high with no memory stalls yields 1 pixel/cycle; first shift_en 2 cycles after start.
//  Window tracking (registered, 1 cycle after shift_en):
//   - shift_cnt counts shifted pixels; k = index of the pixel just shifted.
//   - Window centre index c = k-IMG_WIDTH-1, with c_row/c_col kept as incrementing counters, no divide.
//   - window_valid=1 iff shift_cnt >= 2*IMG_WIDTH+3 and 1 <= c_col <= IMG_WIDTH-2.
//   - Number of valid windows per frame = (W-2)*(H-2).
//  Boundaries:
//   - out_ready low stalls output; reads continue until FIFO full, then stop.
//   - Resumes with no pixel lost or duplicated.
//   - Reset mid-frame: immediate return to IDLE, pending read data discarded, no done.
//   - start coincident with DONE is ignored.
//  Widths: counters sized to hold W*H; no wrap within a frame.
// STRUCTURE
//  Package edge_pkg: IMG_WIDTH/IMG_HEIGHT defaults, pix_t (logic [7:0]), streamer_state_t enum
//  {IDLE,RUN,FLUSH,DONE}.
//  Sub-module: pix_fifo2 (2-entry FIFO, push/pop/count/head). Coordinate counters stay inline.
// TESTING  (W=4,H=4 unless noted)
//  1. Reset then start, out_ready=1, mem holds addr value:
//     - pixel_out 0..15 on 16 consecutive shift_en cycles.
//     - done pulses once; busy drops next cycle.
//  2. Same run: window_valid exactly 4 times, centres (1,1),(1,2),(2,1),(2,2) in that order.
//  3. out_ready toggled 1,0,0,1 pattern:
//     - all 16 pixels delivered in order.
//     - mem_rd_en never issued with fifo_count+inflight=2.
//  4. start pulsed during RUN and during DONE -> ignored: no second frame_clear, pixel count still 16.
//  5. reset_n low at pixel 7:
//     - all outputs 0 asynchronously.
//     - a new start restarts at addr 0 with frame_clear=1.
//  6. W=540,H=540 smoke: 291600 shift_en, 289444 window_valid, single done.

Source files
------------

// File: rtl/edge_pkg.sv
// ============================================================================
// edge_pkg : shared types and default frame geometry for the edge pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package edge_pkg;

    localparam int DEF_IMG_WIDTH  = 540;
    localparam int DEF_IMG_HEIGHT = 540;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } streamer_state_t;

endpackage

`default_nettype wire

// File: rtl/pix_fifo2.sv
// ============================================================================
// pix_fifo2 : two-entry pixel FIFO absorbing frame-memory read returns
// Rev 1.0
// ============================================================================
`default_nettype none

module pix_fifo2
    import edge_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  pix_t       push_data,
    input  logic       pop,
    output pix_t       head,
    output logic [1:0] count,
    output logic       not_empty
);

    pix_t       r_slot0;
    pix_t       r_slot1;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    // The producer never pushes into a full FIFO and never pops an empty one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot0  <= '0;
            r_slot1  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                if (r_wr_ptr) r_slot1 <= push_data;
                else          r_slot0 <= push_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) r_rd_ptr <= ~r_rd_ptr;
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head      = r_rd_ptr ? r_slot1 : r_slot0;
    assign count     = r_count;
    assign not_empty = (r_count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/pixel_streamer.sv
// ============================================================================
// pixel_streamer : streams a raster frame from memory into the 3x3 line buffer
// and flags complete interior windows with their centre coordinates. Rev 1.0
// ============================================================================
`default_nettype none

module pixel_streamer
    import edge_pkg::*;
#(
    parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter  int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int ROW_W      = $clog2(IMG_HEIGHT),
    localparam int COL_W      = $clog2(IMG_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_clear,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  pix_t                  mem_rd_data,
    input  logic                  out_ready,
    output logic                  shift_en,
    output pix_t                  pixel_out,
    output logic                  window_valid,
    output logic [ROW_W-1:0]      center_row,
    output logic [COL_W-1:0]      center_col
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CENTER_FROM = CNT_W'(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0]      VALID_FROM  = CNT_W'(2 * IMG_WIDTH + 2);
    localparam logic [COL_W-1:0]      COL_LAST    = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]      COL_MAX     = COL_W'(IMG_WIDTH - 2);
    localparam logic [COL_W-1:0]      COL_ONE     = COL_W'(1);
    localparam logic [ROW_W-1:0]      ROW_ONE     = ROW_W'(1);

    streamer_state_t r_state;
    streamer_state_t w_next_state;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_inflight;
    logic [1:0]            w_fifo_count;
    logic                  w_fifo_not_empty;
    logic [2:0]            w_occ;
    logic                  w_room;
    logic [CNT_W-1:0]      r_shift_cnt;
    logic [ROW_W-1:0]      r_c_row;
    logic [COL_W-1:0]      r_c_col;

    pix_fifo2 u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (r_inflight),
        .push_data (mem_rd_data),
        .pop       (shift_en),
        .head      (pixel_out),
        .count     (w_fifo_count),
        .not_empty (w_fifo_not_empty)
    );

    assign shift_en = w_fifo_not_empty & out_ready;

    // Occupancy counts the read already in flight, so a new read never overflows.
    assign w_occ  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, shift_en};
    assign w_room = (w_occ < 3'd2);

    assign mem_addr = (r_state == RUN) ? r_rd_addr : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // The first read goes out on the start cycle itself.
    always_comb begin
        w_next_state = r_state;
        frame_clear  = 1'b0;
        mem_rd_en    = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = start;
                if (start) begin
                    frame_clear  = 1'b1;
                    mem_rd_en    = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                mem_rd_en = w_room;
                if (w_room && (r_rd_addr == LAST_ADDR)) w_next_state = FLUSH;
            end
            FLUSH: begin
                if (!w_fifo_not_empty && !r_inflight) w_next_state = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= mem_rd_en;
            if (frame_clear)
                r_rd_addr <= ADDR_ONE;
            else if ((r_state == RUN) && mem_rd_en && (r_rd_addr != LAST_ADDR))
                r_rd_addr <= r_rd_addr + ADDR_ONE;
        end
    end

    // Centre counters start once pixel W+1 is shifted (centre index 0).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_cnt  <= '0;
            r_c_row      <= '0;
            r_c_col      <= '0;
            window_valid <= 1'b0;
            center_row   <= '0;
            center_col   <= '0;
        end else if (frame_clear) begin
            r_shift_cnt  <= '0;
            r_c_row      <= '0;
            r_c_col      <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            if (shift_en) begin
                r_shift_cnt <= r_shift_cnt + CNT_ONE;
                if (r_shift_cnt >= CENTER_FROM) begin
                    window_valid <= (r_shift_cnt >= VALID_FROM) &&
                                    (r_c_col >= COL_ONE) && (r_c_col <= COL_MAX);
                    center_row   <= r_c_row;
                    center_col   <= r_c_col;
                    if (r_c_col == COL_LAST) begin
                        r_c_col <= '0;
                        r_c_row <= r_c_row + ROW_ONE;
                    end else begin
                        r_c_col <= r_c_col + COL_ONE;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_streamer.sv
// ============================================================================
// tb_pixel_streamer : directed scoreboard bench for pixel_streamer at 4x4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pixel_streamer;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic       busy, done, frame_clear, mem_rd_en, shift_en, window_valid;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data = 8'd0;
    logic [7:0] pixel_out;
    logic [1:0] center_row, center_col;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_shift = 0, n_win = 0, n_done = 0, n_clear = 0;
    int first_cyc = 0, last_cyc = 0, start_cyc = 0;
    int m_fifo = 0, m_infl = 0, m_addr = 0;

    logic [7:0] exp_pix[$];
    logic [3:0] exp_win[$];

    pixel_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .frame_clear  (frame_clear),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .out_ready    (out_ready),
        .shift_en     (shift_en),
        .pixel_out    (pixel_out),
        .window_valid (window_valid),
        .center_row   (center_row),
        .center_col   (center_col)
    );

    always #5 clock = ~clock;

    // Frame memory: each location holds its own address, 1-cycle read latency.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= {4'd0, mem_addr};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor and read-side invariants, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            m_fifo = 0;
            m_infl = 0;
            m_addr = 0;
        end else begin
            if (frame_clear) begin
                n_clear++;
                m_addr = 0;
            end
            if (done) n_done++;
            if (mem_rd_en) begin
                check("rd_room", ((m_fifo + m_infl - int'(shift_en)) < 2), 1);
                check("rd_addr", mem_addr, m_addr);
                m_addr++;
            end
            m_fifo = m_fifo + m_infl - int'(shift_en);
            m_infl = int'(mem_rd_en);
            if (shift_en) begin
                if (n_shift == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_pix.size() == 0) check("pix_extra", n_shift + 1, NPIX);
                else                     check("pixel", pixel_out, exp_pix.pop_front());
                n_shift++;
            end
            if (window_valid) begin
                if (exp_win.size() == 0) check("win_extra", n_win + 1, (W-2)*(H-2));
                else                     check("win_centre", {center_row, center_col}, exp_win.pop_front());
                n_win++;
            end
        end
    end

    task automatic load_expect();
        logic [31:0] v;
        exp_pix.delete();
        exp_win.delete();
        for (int p = 0; p < NPIX; p++) begin
            v = p;
            exp_pix.push_back(v[7:0]);
        end
        for (int r = 1; r <= H-2; r++)
            for (int c = 1; c <= W-2; c++) begin
                v = (r << 2) | c;
                exp_win.push_back(v[3:0]);
            end
        n_shift = 0; n_win = 0; n_done = 0; n_clear = 0;
    endtask

    task automatic run_frame(input bit toggle, input bit poke);
        bit saw_done;
        load_expect();
        @(posedge clock); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        check("start_clear", frame_clear, 1);
        check("start_rd_en", mem_rd_en, 1);
        check("start_addr", mem_addr, 0);
        check("start_busy", busy, 1);
        saw_done = 1'b0;
        for (int i = 1; i < 200; i++) begin
            @(posedge clock); #1;
            start     = poke && (i == 5);
            out_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            @(negedge clock);
            if (done) begin
                saw_done = 1'b1;
                check("busy_at_done", busy, 1);
                if (poke) start = 1'b1;
                break;
            end
        end
        check("done_seen", saw_done, 1);
        @(posedge clock); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("busy_after_done", busy, 0);
        check("done_single_cycle", done, 0);
        repeat (3) @(negedge clock);
        check("pix_count", n_shift, NPIX);
        check("win_count", n_win, (W-2)*(H-2));
        check("done_count", n_done, 1);
        check("clear_count", n_clear, 1);
        check("pix_left", exp_pix.size(), 0);
        check("win_left", exp_win.size(), 0);
        check("idle_busy", busy, 0);
        if (!toggle) begin
            check("first_shift_lat", first_cyc - start_cyc, 2);
            check("shift_span", last_cyc - first_cyc, NPIX - 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_clear"}, frame_clear, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_shift"}, shift_en, 0);
        check({tag, "_pixel"}, pixel_out, 0);
        check({tag, "_wvalid"}, window_valid, 0);
        check({tag, "_crow"}, center_row, 0);
        check({tag, "_ccol"}, center_col, 0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 check_all_zero("reset");
        reset_n = 1'b1;

        // Free-running frame, then backpressured frame.
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        // start pulsed during RUN and on the DONE cycle.
        run_frame(1'b0, 1'b1);

        // Abort mid-frame once pixel 7 has gone out.
        load_expect();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 0; i < 100 && n_shift < 8; i++) begin
            @(posedge clock); #1;
        end
        check("pre_reset_shifts", n_shift, 8);
        check("pre_reset_done", n_done, 0);
        reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_pix.delete();
        exp_win.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("post_reset_done", n_done, 0);
        run_frame(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
